// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, constants and field-width helpers for the data cache
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_RESPOND
    } state_e;

    localparam logic MEM_RW_READ  = 1'b0;
    localparam logic MEM_RW_WRITE = 1'b1;

    function automatic int log2i(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Tag covers whatever remains of the 30-bit word address after index and word offset.
    function automatic int tag_width(input int lines, input int words_per_line);
        return 30 - log2i(lines) - log2i(words_per_line);
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// rtl/dcache_responder_if.sv - core dcache port and line-refill memory port bundle
interface dcache_responder_if;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport slave (
        input  dcache_addr, dcache_re, dcache_we, dcache_din,
        output dcache_dout, stall,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output dcache_addr, dcache_re, dcache_we, dcache_din,
        input  dcache_dout, stall,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - tag, valid and data arrays with combinational read and byte-masked write
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int OFF_W          = log2i(WORDS_PER_LINE),
    parameter int IDX_W          = log2i(LINES),
    parameter int TAG_W          = tag_width(LINES, WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] index,
    input  logic [OFF_W-1:0] rd_word,
    output logic [31:0]      rd_data,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [OFF_W-1:0] wr_word,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_mask,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] tag_wdata
);
    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES*WORDS_PER_LINE];

    assign rd_data  = data_q[{index, rd_word}];
    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];

    always_comb begin
        valid_d = valid_q;
        if (tag_we) valid_d[index] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (tag_we) tag_q[index] <= tag_wdata;
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) data_q[{index, wr_word}][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - blocking direct-mapped write-through data cache; DCACHE_WRITE_BUFFER_EN adds a posted write buffer
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              reset,
    dcache_responder_if.slave bus
);
    localparam int OFF_W = log2i(WORDS_PER_LINE);
    localparam int IDX_W = log2i(LINES);
    localparam int TAG_W = tag_width(LINES, WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    state_e           state_q, state_d;
    logic             lookup_q, lookup_d;
    logic [29:0]      req_addr_q, req_addr_d;
    logic [3:0]       req_we_q, req_we_d;
    logic [31:0]      req_din_q, req_din_d;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic [31:0]      dout_q, dout_d;

    logic [OFF_W-1:0] req_word;
    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] req_tag;
    logic             req_is_write, hit;

    logic [31:0]      rd_data;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             wr_en, tag_we;
    logic [OFF_W-1:0] wr_word;
    logic [31:0]      wr_data;
    logic [3:0]       wr_mask;

    logic             stall, wbuf_busy;
    logic             mem_req_valid, mem_req_rw;
    logic [31:0]      mem_req_addr, mem_req_wdata;
    logic [3:0]       mem_req_wmask;

`ifdef DCACHE_WRITE_BUFFER_EN
    logic        wbuf_valid_q, wbuf_valid_d;
    logic [29:0] wbuf_addr_q, wbuf_addr_d;
    logic [31:0] wbuf_data_q, wbuf_data_d;
    logic [3:0]  wbuf_mask_q, wbuf_mask_d;
    assign wbuf_busy = wbuf_valid_q;
`else
    assign wbuf_busy = 1'b0;
`endif

    assign req_word     = req_addr_q[OFF_W-1:0];
    assign req_index    = req_addr_q[OFF_W +: IDX_W];
    assign req_tag      = req_addr_q[29 -: TAG_W];
    assign req_is_write = |req_we_q;
    assign hit          = rd_valid && (rd_tag == req_tag);

    dcache_line_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_store (
        .clk       (clk),
        .rst_n     (reset),
        .index     (req_index),
        .rd_word   (req_word),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .tag_we    (tag_we),
        .tag_wdata (req_tag)
    );

    always_comb begin
        state_d       = state_q;
        lookup_d      = 1'b0;
        req_addr_d    = req_addr_q;
        req_we_d      = req_we_q;
        req_din_d     = req_din_q;
        beat_d        = beat_q;
        dout_d        = dout_q;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = MEM_RW_READ;
        mem_req_addr  = {req_addr_q[29:OFF_W], {OFF_W{1'b0}}, 2'b00};
        mem_req_wdata = req_din_q;
        mem_req_wmask = req_we_q;
        wr_en         = 1'b0;
        wr_word       = req_word;
        wr_data       = req_din_q;
        wr_mask       = req_we_q;
        tag_we        = 1'b0;
`ifdef DCACHE_WRITE_BUFFER_EN
        wbuf_valid_d  = wbuf_valid_q;
        wbuf_addr_d   = wbuf_addr_q;
        wbuf_data_d   = wbuf_data_q;
        wbuf_mask_d   = wbuf_mask_q;
        // The buffered write owns the memory port until it drains; refills queue behind it.
        if (wbuf_valid_q) begin
            mem_req_valid = 1'b1;
            mem_req_rw    = MEM_RW_WRITE;
            mem_req_addr  = {wbuf_addr_q, 2'b00};
            mem_req_wdata = wbuf_data_q;
            mem_req_wmask = wbuf_mask_q;
            if (bus.mem_req_ready) wbuf_valid_d = 1'b0;
        end
`endif

        unique case (state_q)
            S_IDLE: begin
                if (lookup_q) begin
                    if (req_is_write) begin
                        wr_en = hit;
`ifdef DCACHE_WRITE_BUFFER_EN
                        if (!wbuf_valid_d) begin
                            wbuf_valid_d = 1'b1;
                            wbuf_addr_d  = req_addr_q;
                            wbuf_data_d  = req_din_q;
                            wbuf_mask_d  = req_we_q;
                        end else begin
                            stall = 1'b1;
                        end
`else
                        stall   = 1'b1;
                        state_d = S_WRITE;
`endif
                    end else if (hit) begin
                        dout_d = rd_data;
                    end else begin
                        stall   = 1'b1;
                        state_d = S_REFILL_REQ;
                    end
                end
            end
            S_WRITE: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_rw    = MEM_RW_WRITE;
                mem_req_addr  = {req_addr_q, 2'b00};
                if (bus.mem_req_ready) state_d = S_IDLE;
            end
            S_REFILL_REQ: begin
                stall = 1'b1;
                if (!wbuf_busy) begin
                    mem_req_valid = 1'b1;
                    if (bus.mem_req_ready) state_d = S_REFILL_WAIT;
                end
            end
            S_REFILL_WAIT: begin
                stall = 1'b1;
                if (bus.mem_resp_valid) begin
                    wr_en   = 1'b1;
                    wr_word = beat_q;
                    wr_data = bus.mem_resp_data;
                    wr_mask = 4'hF;
                    beat_d  = beat_q + OFF_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        tag_we  = 1'b1;
                        state_d = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                dout_d  = rd_data;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A lookup stalled in IDLE (buffer full) keeps its request pending.
        if (!stall && (bus.dcache_re || (bus.dcache_we != 4'b0000))) begin
            lookup_d   = 1'b1;
            req_addr_d = bus.dcache_addr[31:2];
            req_we_d   = bus.dcache_we;
            req_din_d  = bus.dcache_din;
        end else begin
            lookup_d = lookup_q && stall && (state_d == S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            lookup_q   <= 1'b0;
            req_addr_q <= '0;
            req_we_q   <= '0;
            req_din_q  <= '0;
            beat_q     <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            lookup_q   <= lookup_d;
            req_addr_q <= req_addr_d;
            req_we_q   <= req_we_d;
            req_din_q  <= req_din_d;
            beat_q     <= beat_d;
            dout_q     <= dout_d;
        end
    end

`ifdef DCACHE_WRITE_BUFFER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbuf_valid_q <= 1'b0;
            wbuf_addr_q  <= '0;
            wbuf_data_q  <= '0;
            wbuf_mask_q  <= '0;
        end else begin
            wbuf_valid_q <= wbuf_valid_d;
            wbuf_addr_q  <= wbuf_addr_d;
            wbuf_data_q  <= wbuf_data_d;
            wbuf_mask_q  <= wbuf_mask_d;
        end
    end
`endif

    assign bus.dcache_dout   = dout_d;
    assign bus.stall         = stall;
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_req_rw    = mem_req_rw;
    assign bus.mem_req_addr  = mem_req_addr;
    assign bus.mem_req_wdata = mem_req_wdata;
    assign bus.mem_req_wmask = mem_req_wmask;

endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - directed self-checking bench for dcache_responder
module tb_dcache_responder;
    logic clk = 1'b0;
    logic reset_n;
    int   nvec = 0;
    int   nerr = 0;

    dcache_responder_if bus ();

    dcache_responder #(
        .LINES          (64),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n            = 1'b0;
        bus.dcache_addr    = '0;
        bus.dcache_re      = 1'b0;
        bus.dcache_we      = 4'b0000;
        bus.dcache_din     = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        tick;
        tick;
        #1;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_dout", bus.dcache_dout, 32'd0);
        reset_n = 1'b1;

        // cold read miss of 0x104
        bus.dcache_addr = 32'h0000_0104;
        bus.dcache_re   = 1'b1;
        #1;
        chk("idle_stall", 32'(bus.stall), 32'd0);
        tick;
        bus.dcache_re = 1'b0;
        #1;
        chk("miss_lookup_stall", 32'(bus.stall), 32'd1);
        tick;
        #1;
        chk("refill_req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("refill_req_rw", 32'(bus.mem_req_rw), 32'd0);
        chk("refill_req_addr", bus.mem_req_addr, 32'h0000_0100);
        chk("refill_req_stall", 32'(bus.stall), 32'd1);
        bus.mem_req_ready = 1'b1;
        tick;
        bus.mem_req_ready = 1'b0;
        #1;
        chk("refill_req_drop", 32'(bus.mem_req_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("refill_wait_stall", 32'(bus.stall), 32'd1);
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'h0000_00A0 + 32'(i);
            tick;
        end
        bus.mem_resp_valid = 1'b0;
        bus.dcache_addr    = 32'h0000_0108;
        bus.dcache_re      = 1'b1;
        #1;
        chk("respond_stall", 32'(bus.stall), 32'd0);
        chk("respond_dout", bus.dcache_dout, 32'h0000_00A1);

        // back-to-back hits
        tick;
        bus.dcache_addr = 32'h0000_010C;
        #1;
        chk("hit1_stall", 32'(bus.stall), 32'd0);
        chk("hit1_dout", bus.dcache_dout, 32'h0000_00A2);
        tick;
        bus.dcache_re = 1'b0;
        #1;
        chk("hit2_stall", 32'(bus.stall), 32'd0);
        chk("hit2_dout", bus.dcache_dout, 32'h0000_00A3);
        tick;
        #1;
        chk("hold_dout", bus.dcache_dout, 32'h0000_00A3);

        // masked write hit to 0x104
        bus.dcache_addr = 32'h0000_0104;
        bus.dcache_we   = 4'b0011;
        bus.dcache_din  = 32'hDEAD_BEEF;
        tick;
        bus.dcache_we = 4'b0000;
        #1;
        chk("wr_lookup_stall", 32'(bus.stall), 32'd1);
        chk("wr_dout_unchanged", bus.dcache_dout, 32'h0000_00A3);
        tick;
        #1;
        chk("wr_req_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("wr_req_rw", 32'(bus.mem_req_rw), 32'd1);
        chk("wr_req_addr", bus.mem_req_addr, 32'h0000_0104);
        chk("wr_req_wdata", bus.mem_req_wdata, 32'hDEAD_BEEF);
        chk("wr_req_wmask", 32'(bus.mem_req_wmask), 32'h3);
        bus.mem_req_ready = 1'b1;
        tick;
        bus.mem_req_ready = 1'b0;
        #1;
        chk("wr_release_stall", 32'(bus.stall), 32'd0);
        chk("wr_req_drop", 32'(bus.mem_req_valid), 32'd0);
        bus.dcache_re = 1'b1;
        tick;
        bus.dcache_re = 1'b0;
        #1;
        chk("wr_hit_stall", 32'(bus.stall), 32'd0);
        chk("wr_merge_dout", bus.dcache_dout, 32'h0000_BEEF);
        tick;

        // write miss to 0x2000 with ready backpressure
        bus.dcache_addr = 32'h0000_2000;
        bus.dcache_we   = 4'b1111;
        bus.dcache_din  = 32'h1234_5678;
        tick;
        bus.dcache_we = 4'b0000;
        #1;
        chk("wmiss_lookup_stall", 32'(bus.stall), 32'd1);
        tick;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("bp_addr", bus.mem_req_addr, 32'h0000_2000);
            chk("bp_wdata", bus.mem_req_wdata, 32'h1234_5678);
            chk("bp_wmask", 32'(bus.mem_req_wmask), 32'hF);
            chk("bp_stall", 32'(bus.stall), 32'd1);
            tick;
            #1;
        end
        bus.mem_req_ready = 1'b1;
        tick;
        bus.mem_req_ready = 1'b0;
        #1;
        chk("bp_release_stall", 32'(bus.stall), 32'd0);
        bus.dcache_re = 1'b1;
        tick;
        bus.dcache_re = 1'b0;
        #1;
        chk("wmiss_no_allocate", 32'(bus.stall), 32'd1);
        tick;
        #1;
        chk("wmiss_refill_addr", bus.mem_req_addr, 32'h0000_2000);
        chk("wmiss_refill_rw", 32'(bus.mem_req_rw), 32'd0);

        // reset after beat 1 of the refill
        bus.mem_req_ready = 1'b1;
        tick;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_00B0;
        tick;
        bus.mem_resp_data = 32'h0000_00B1;
        tick;
        bus.mem_resp_valid = 1'b0;
        reset_n            = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(bus.stall), 32'd0);
        chk("rst_mid_req_valid", 32'(bus.mem_req_valid), 32'd0);
        tick;
        reset_n       = 1'b1;
        bus.dcache_re = 1'b1;
        tick;
        bus.dcache_re = 1'b0;
        #1;
        chk("post_rst_miss", 32'(bus.stall), 32'd1);
        tick;
        #1;
        chk("post_rst_req_addr", bus.mem_req_addr, 32'h0000_2000);
        bus.mem_req_ready = 1'b1;
        tick;
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'h0000_00C0 + 32'(i);
            tick;
        end
        bus.mem_resp_valid = 1'b0;
        bus.dcache_addr    = 32'h0000_0104;
        bus.dcache_re      = 1'b1;
        #1;
        chk("post_rst_dout", bus.dcache_dout, 32'h0000_00C0);
        chk("post_rst_respond_stall", 32'(bus.stall), 32'd0);
        tick;
        bus.dcache_re = 1'b0;
        #1;
        chk("post_rst_old_line_invalid", 32'(bus.stall), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Blocking, direct-mapped, write-through / no-write-allocate data cache.
- It is the responder on the core's dcache port: it services the address, read-enable, byte write-enable and write-data signals, and returns read data plus the shared stall.
- The back end is a line-refill memory port with valid/ready handshake.
- Sits between the core and the memory arbiter.

Parameters:
- LINES, 64, number of cache lines (power of 2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- dcache_addr  input  32  byte address from core; bits [1:0] ignored.
- dcache_re  input  1  read request.
- dcache_we  input  4  byte write enables; nonzero means write request.
- dcache_din  input  32  write data, byte lanes aligned to dcache_we.
- dcache_dout  output  32  read data.
- stall  output  1  high while a request is unresolved; core freezes.
- mem_req_valid  output  1  memory request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_rw  output  1  1 = write word, 0 = read line.
- mem_req_addr  output  32  word-aligned address; line-aligned for reads.
- mem_req_wdata  output  32  write data.
- mem_req_wmask  output  4  write byte mask.
- mem_resp_valid  input  1  one refill beat valid.
- mem_resp_data  input  32  refill beat, ascending word order.

Behaviour:
- Address split: byte offset [1:0]; word offset next log2(WORDS_PER_LINE) bits; index next log2(LINES) bits; tag = remaining upper bits.
- Acceptance: a request is accepted on a rising edge with stall==0 and (dcache_re or dcache_we!=0). If both are set, it is treated as a write. Inputs are ignored while stall==1.
- Storage: the accepted request (addr, we, din) is registered. Tag, valid and data arrays are indexed from the registered address in the following cycle (LOOKUP).
- FSM states: IDLE/LOOKUP, WRITE, REFILL_REQ, REFILL_WAIT, RESPOND.
- Read hit: dcache_dout = line word in the cycle after acceptance; stall=0; zero-bubble back-to-back hits.
- Read miss:
  - stall=1 combinationally in the lookup cycle; go to REFILL_REQ.
  - REFILL_REQ drives mem_req_valid=1, rw=0, addr=line base until mem_req_ready; then REFILL_WAIT.
  - REFILL_WAIT writes each mem_resp_valid beat into the data array at a beat counter (0..WORDS_PER_LINE-1; it wraps to 0 after the last beat).
  - After the last beat: set valid, write the tag, go to RESPOND.
  - RESPOND drives dcache_dout = requested word, stall=0, and returns to IDLE.
- Write (hit or miss):
  - On a hit, merge masked bytes into the line during the lookup cycle. On a miss, leave the cache unchanged.
  - Go to WRITE with stall=1: mem_req_valid=1, rw=1, addr=word address, wdata=din, wmask=we, held until mem_req_ready. Release stall on the cycle after the handshake.
- dcache_dout holds its last read value until the next read completes; writes never change it.
- mem_req_* fields stay stable while mem_req_valid=1 and mem_req_ready=0.
- Reset values: all valid bits 0, state IDLE, stall 0, mem_req_valid 0, dcache_dout 0, beat counter 0.
- Reset mid-refill aborts the refill; the line stays invalid. The memory side is reset on the same signal, so no stale beats arrive.
- A mem_resp_valid received outside REFILL_WAIT is ignored.

Optional Feature:
- Macro: DCACHE_WRITE_BUFFER_EN.
- Enabled:
  - Adds a 1-entry posted write buffer. A write loads the buffer and releases stall the next cycle; the buffer drains to memory in the background.
  - A new write while the buffer is full stalls until it drains.
  - A read miss stalls until the buffer drains before REFILL_REQ, preserving memory ordering.
  - A read hit proceeds concurrently.
- Disabled: writes block as described in Behaviour.

Decomposition:
- Shared package dcache_pkg holds:
  - the state enum;
  - the function computing field widths from LINES/WORDS_PER_LINE;
  - the constants MEM_RW_READ=0 and MEM_RW_WRITE=1.
- One sub-module, dcache_line_store, holds the tag, valid and data arrays, with a combinational read port and a byte-masked write port.

Test Plan:
- Cold read miss: read 0x0000_0104 with memory returning 0xA0..0xA3 → one line request at 0x0000_0100; stall high until RESPOND; dcache_dout=0xA1.
- Read hits: then read 0x0000_0108 and 0x0000_010C back-to-back → stall stays 0; dout=0xA2 then 0xA3 on consecutive cycles.
- Write hit with byte mask: write we=4'b0011, din=0xDEAD_BEEF to 0x0000_0104 → memory write with mask 0011; a later read of 0x104 returns 0x0000_BEEF (upper bytes from 0xA1=0x0000_00A1).
- Write miss then read: write to 0x0000_2000 → no refill and cache unchanged; a read of 0x0000_2000 then misses and refills.
- Ready backpressure: hold mem_req_ready=0 for 5 cycles → mem_req_* stable, stall held; completes one cycle after ready.
- Reset mid-refill: drop reset after beat 1 → stall=0, mem_req_valid=0 immediately; the same read after reset misses again.
